register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 111 +++++++++++
 1 files changed

// File: rtl/register_file.sv
// General-purpose register file with NZCV status register and branch-condition evaluator.
// Optional write-through read bypass is enabled by defining RF_BYPASS_EN.
module register_file #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    localparam int ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RdAddrA,
    input  logic [ADDR_W-1:0] RdAddrB,
    output logic [DATA_W-1:0] A_out,
    output logic [DATA_W-1:0] B_out,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              FlagsWrEn,
    input  logic [3:0]        FlagsNZCV_in,
    output logic [3:0]        FlagsNZCV,
    output logic              AddSubCBin,
    input  logic [3:0]        Cond,
    output logic              CondTrue
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [3:0]        flags_reg;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [DATA_W-1:0] data_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_reg <= '0;
                end else if (WrEn && (WrAddr == ADDR_W'(gi))) begin
                    data_reg <= WrData;
                end
            end

            assign regs_q[gi] = data_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_reg <= 4'b0000;
        end else if (FlagsWrEn) begin
            flags_reg <= FlagsNZCV_in;
        end
    end

    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;

    always_comb begin
        stored_a = '0;
        stored_b = '0;
        if (32'(RdAddrA) < NREGS) stored_a = regs_q[RdAddrA];
        if (32'(RdAddrB) < NREGS) stored_b = regs_q[RdAddrB];
    end

`ifdef RF_BYPASS_EN
    // Write data is forwarded only when the write will actually land, so reset masks it.
    logic bypass_a;
    logic bypass_b;

    assign bypass_a = WrEn && !reset && (RdAddrA == WrAddr);
    assign bypass_b = WrEn && !reset && (RdAddrB == WrAddr);
    assign A_out    = bypass_a ? WrData : stored_a;
    assign B_out    = bypass_b ? WrData : stored_b;
`else
    assign A_out = stored_a;
    assign B_out = stored_b;
`endif

    assign FlagsNZCV  = flags_reg;
    assign AddSubCBin = flags_reg[1];

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = flags_reg[3];
    assign flag_z = flags_reg[2];
    assign flag_c = flags_reg[1];
    assign flag_v = flags_reg[0];

    always_comb begin
        CondTrue = 1'b0;
        case (Cond)
            4'b0000: CondTrue = flag_z;
            4'b0001: CondTrue = !flag_z;
            4'b0010: CondTrue = flag_c;
            4'b0011: CondTrue = !flag_c;
            4'b0100: CondTrue = flag_n;
            4'b0101: CondTrue = !flag_n;
            4'b0110: CondTrue = flag_v;
            4'b0111: CondTrue = !flag_v;
            4'b1000: CondTrue = flag_c && !flag_z;
            4'b1001: CondTrue = !flag_c || flag_z;
            4'b1010: CondTrue = (flag_n == flag_v);
            4'b1011: CondTrue = (flag_n != flag_v);
            4'b1100: CondTrue = !flag_z && (flag_n == flag_v);
            4'b1101: CondTrue = flag_z || (flag_n != flag_v);
            4'b1110: CondTrue = 1'b1;
            default: CondTrue = 1'b0;
        endcase
    end

endmodule
